// File: rtl/board_commit_ctrl.sv
// board_commit_ctrl
//   Sequencer for the 2048 board register and its 2-way board mux
//   (sel=0 holds the current board, sel=1 loads the captured moved board).
//   A move request captures the candidate board, drops no-op moves,
//   commits the new board and spawns a tile at a pseudo-random empty cell.
//   A new-game request clears the board and spawns two tiles.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   new_game            start a new game (accepted when move_ready=1)
//   move_valid          move request (accepted when move_ready=1, new_game=0)
//   moved_board         candidate board, sampled on the accept cycle only
//   move_ready          controller idle
//   sel                 board mux select, high during the commit cycle
//   board               registered current board, board[row][col]
//   spawn_valid         one-cycle pulse when a tile is spawned
//   spawn_row/col       spawned cell, valid with spawn_valid
//   changed             board altered, valid with done
//   done                one-cycle pulse ending every accepted request
//   win                 sticky: a WIN_VALUE tile has been seen
//   full                no empty cell left, updated with done
module board_commit_ctrl #(
  parameter int unsigned TILE_W      = 12,
  parameter int unsigned WIN_VALUE   = 2048,
  parameter int unsigned SPAWN_VALUE = 2,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         new_game,
  input  logic                         move_valid,
  input  logic [3:0][3:0][TILE_W-1:0]  moved_board,
  output logic                         move_ready,
  output logic                         sel,
  output logic [3:0][3:0][TILE_W-1:0]  board,
  output logic                         spawn_valid,
  output logic [1:0]                   spawn_row,
  output logic [1:0]                   spawn_col,
  output logic                         changed,
  output logic                         done,
  output logic                         win,
  output logic                         full
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_COMMIT,
    S_SEARCH,
    S_SPAWN,
    S_FINISH
  } state_t;

  localparam logic [TILE_W-1:0] WIN_TILE   = TILE_W'(WIN_VALUE);
  localparam logic [TILE_W-1:0] SPAWN_TILE = TILE_W'(SPAWN_VALUE);

  state_t                        state_q, state_d;
  logic [15:0]                   lfsr_q, lfsr_d;
  logic [3:0][3:0][TILE_W-1:0]   board_q, board_d;
  logic [3:0][3:0][TILE_W-1:0]   shadow_q, shadow_d;
  logic [3:0]                    idx_q, idx_d;
  logic [3:0]                    scanned_q, scanned_d;
  logic [1:0]                    spawn_cnt_q, spawn_cnt_d;
  logic                          spawn_valid_q, spawn_valid_d;
  logic [1:0]                    spawn_row_q, spawn_row_d;
  logic [1:0]                    spawn_col_q, spawn_col_d;
  logic                          changed_q, changed_d;
  logic                          done_q, done_d;
  logic                          win_q, win_d;
  logic                          full_q, full_d;

  logic                          board_has_zero;
  logic                          board_has_win;

  // Fibonacci LFSR, taps 16,14,13,11; free-running.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_comb begin
    board_has_zero = 1'b0;
    board_has_win  = 1'b0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        if (board_q[r][c] == '0)      board_has_zero = 1'b1;
        if (board_q[r][c] == WIN_TILE) board_has_win  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    shadow_d      = shadow_q;
    idx_d         = idx_q;
    scanned_d     = scanned_q;
    spawn_cnt_d   = spawn_cnt_q;
    spawn_valid_d = 1'b0;
    spawn_row_d   = spawn_row_q;
    spawn_col_d   = spawn_col_q;
    changed_d     = 1'b0;
    done_d        = 1'b0;
    win_d         = win_q;
    full_d        = full_q;
    move_ready    = 1'b0;
    sel           = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        move_ready = 1'b1;
        if (new_game) begin
          board_d     = '0;
          win_d       = 1'b0;
          spawn_cnt_d = 2'd2;
          idx_d       = lfsr_q[3:0];
          scanned_d   = '0;
          state_d     = S_SEARCH;
        end else if (move_valid) begin
          shadow_d = moved_board;
          state_d  = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (shadow_q == board_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        sel         = 1'b1;
        board_d     = shadow_q;
        spawn_cnt_d = 2'd1;
        idx_d       = lfsr_q[3:0];
        scanned_d   = '0;
        state_d     = S_SEARCH;
      end
      S_SEARCH: begin
        if (board_q[idx_q[3:2]][idx_q[1:0]] == '0) begin
          state_d = S_SPAWN;
        end else if (scanned_q == 4'd15) begin
          // Every cell tested once: board is full, finish without a spawn.
          state_d = S_FINISH;
        end else begin
          idx_d     = idx_q + 4'd1;
          scanned_d = scanned_q + 4'd1;
        end
      end
      S_SPAWN: begin
        board_d[idx_q[3:2]][idx_q[1:0]] = SPAWN_TILE;
        spawn_valid_d = 1'b1;
        spawn_row_d   = idx_q[3:2];
        spawn_col_d   = idx_q[1:0];
        spawn_cnt_d   = spawn_cnt_q - 2'd1;
        if (spawn_cnt_q == 2'd1) begin
          state_d = S_FINISH;
        end else begin
          idx_d     = lfsr_q[3:0];
          scanned_d = '0;
          state_d   = S_SEARCH;
        end
      end
      S_FINISH: begin
        done_d    = 1'b1;
        changed_d = 1'b1;
        full_d    = ~board_has_zero;
        win_d     = win_q | board_has_win;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lfsr_q        <= SEED;
      board_q       <= '0;
      shadow_q      <= '0;
      idx_q         <= '0;
      scanned_q     <= '0;
      spawn_cnt_q   <= '0;
      spawn_valid_q <= 1'b0;
      spawn_row_q   <= '0;
      spawn_col_q   <= '0;
      changed_q     <= 1'b0;
      done_q        <= 1'b0;
      win_q         <= 1'b0;
      full_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      board_q       <= board_d;
      shadow_q      <= shadow_d;
      idx_q         <= idx_d;
      scanned_q     <= scanned_d;
      spawn_cnt_q   <= spawn_cnt_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_row_q   <= spawn_row_d;
      spawn_col_q   <= spawn_col_d;
      changed_q     <= changed_d;
      done_q        <= done_d;
      win_q         <= win_d;
      full_q        <= full_d;
    end
  end

  assign board       = board_q;
  assign spawn_valid = spawn_valid_q;
  assign spawn_row   = spawn_row_q;
  assign spawn_col   = spawn_col_q;
  assign changed     = changed_q;
  assign done        = done_q;
  assign win         = win_q;
  assign full        = full_q;

endmodule

// File: tb/tb_board_commit_ctrl.sv
module tb_board_commit_ctrl;

  localparam int TW = 12;
  typedef logic [3:0][3:0][TW-1:0] board_t;

  typedef struct {
    board_t base;
    bit     chg;
    int     n_spawn;
    int     n_sel;
    bit     exp_win;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       new_game;
  logic       move_valid;
  board_t     moved_board;
  logic       move_ready;
  logic       sel;
  board_t     board;
  logic       spawn_valid;
  logic [1:0] spawn_row;
  logic [1:0] spawn_col;
  logic       changed;
  logic       done;
  logic       win;
  logic       full;

  board_commit_ctrl #(
    .TILE_W      (TW),
    .WIN_VALUE   (2048),
    .SPAWN_VALUE (2),
    .SEED        (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .new_game    (new_game),
    .move_valid  (move_valid),
    .moved_board (moved_board),
    .move_ready  (move_ready),
    .sel         (sel),
    .board       (board),
    .spawn_valid (spawn_valid),
    .spawn_row   (spawn_row),
    .spawn_col   (spawn_col),
    .changed     (changed),
    .done        (done),
    .win         (win),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t   q[$];
  int     spawn_r[$];
  int     spawn_c[$];
  int     sel_cnt = 0;
  int     done_cnt = 0;
  int     done_cyc = 0;
  int     accept_cyc = 0;
  int     last_r = -1;
  int     last_c = -1;
  bit     full_model = 1'b0;
  bit     win_model = 1'b0;
  board_t cur_model = '0;

  exp_t   e;
  board_t exp_b;
  bit     exp_full;

  function automatic bit has_zero(input board_t b);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] == '0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit has_win(input board_t b);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] == TW'(2048)) return 1'b1;
    return 1'b0;
  endfunction

  // Scoreboard: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (sel === 1'b1) sel_cnt++;
      if (spawn_valid === 1'b1) begin
        spawn_r.push_back(int'(spawn_row));
        spawn_c.push_back(int'(spawn_col));
        last_r = int'(spawn_row);
        last_c = int'(spawn_col);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: done=1 observed, required no pending request");
        end else begin
          e = q.pop_front();
          exp_b = e.base;
          checks++;
          if (changed !== e.chg) begin
            errors++;
            $display("FAIL changed: got %b, expected %b", changed, e.chg);
          end
          checks++;
          if (spawn_r.size() != e.n_spawn) begin
            errors++;
            $display("FAIL spawn_count: got %0d, expected %0d", spawn_r.size(), e.n_spawn);
          end
          for (int i = 0; i < spawn_r.size(); i++) begin
            checks++;
            if (exp_b[spawn_r[i]][spawn_c[i]] !== '0) begin
              errors++;
              $display("FAIL spawn_cell: spawn at r%0d c%0d holds %0d, expected an empty cell",
                       spawn_r[i], spawn_c[i], exp_b[spawn_r[i]][spawn_c[i]]);
            end
            exp_b[spawn_r[i]][spawn_c[i]] = TW'(2);
          end
          checks++;
          if (board !== exp_b) begin
            errors++;
            $display("FAIL board: got %h, expected %h", board, exp_b);
          end
          exp_full = e.chg ? !has_zero(exp_b) : full_model;
          checks++;
          if (full !== exp_full) begin
            errors++;
            $display("FAIL full: got %b, expected %b", full, exp_full);
          end
          checks++;
          if (win !== e.exp_win) begin
            errors++;
            $display("FAIL win: got %b, expected %b", win, e.exp_win);
          end
          checks++;
          if (sel_cnt != e.n_sel) begin
            errors++;
            $display("FAIL sel_cycles: got %0d, expected %0d", sel_cnt, e.n_sel);
          end
          full_model = exp_full;
          cur_model  = exp_b;
        end
        spawn_r.delete();
        spawn_c.delete();
        sel_cnt = 0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (move_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (move_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout: move_ready=%b after 200 cycles, expected 1", move_ready);
    end
  endtask

  task automatic wait_done();
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == start) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within 200 cycles, expected one");
    end
  endtask

  task automatic junk_board();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        moved_board[r][c] = TW'($urandom);
  endtask

  task automatic send_move(input board_t b);
    exp_t x;
    wait_ready();
    x.base    = (b == cur_model) ? cur_model : b;
    x.chg     = (b != cur_model);
    x.n_spawn = (x.chg && has_zero(b)) ? 1 : 0;
    x.n_sel   = x.chg ? 1 : 0;
    x.exp_win = x.chg ? (win_model | has_win(b)) : win_model;
    win_model = x.exp_win;
    q.push_back(x);
    moved_board = b;
    move_valid  = 1'b1;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    move_valid = 1'b0;
    junk_board();
  endtask

  task automatic send_new_game();
    exp_t x;
    wait_ready();
    x.base    = '0;
    x.chg     = 1'b1;
    x.n_spawn = 2;
    x.n_sel   = 0;
    x.exp_win = 1'b0;
    win_model = 1'b0;
    q.push_back(x);
    new_game = 1'b1;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    new_game = 1'b0;
    wait_done();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (board !== '0) begin errors++; $display("FAIL reset_board: got %h, expected 0", board); end
    checks++;
    if (move_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", move_ready); end
    checks++;
    if ({win, full, done, sel, spawn_valid, changed} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: win/full/done/sel/spawn/changed got %b, expected 000000",
               {win, full, done, sel, spawn_valid, changed});
    end
  endtask

  task automatic test_new_game();
    send_new_game();
  endtask

  task automatic test_single_empty();
    board_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = TW'(4 * (r * 4 + c + 1));
    b[2][1] = '0;
    send_move(b);
    wait_done();
    checks++;
    if (last_r != 2 || last_c != 1) begin
      errors++;
      $display("FAIL single_spawn_pos: got r%0d c%0d, expected r2 c1", last_r, last_c);
    end
    checks++;
    if (board[2][1] !== TW'(2)) begin
      errors++;
      $display("FAIL single_spawn_val: got %0d, expected 2", board[2][1]);
    end
    checks++;
    if (done_cyc - accept_cyc + 1 < 6) begin
      errors++;
      $display("FAIL single_latency: got %0d, expected at least 6", done_cyc - accept_cyc + 1);
    end
  endtask

  task automatic test_noop();
    board_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = TW'(4 * (r * 4 + c + 1));
    b[2][1] = TW'(2);
    send_move(b);
    wait_done();
    checks++;
    if (done_cyc - accept_cyc + 1 != 2) begin
      errors++;
      $display("FAIL noop_latency: got %0d, expected 2", done_cyc - accept_cyc + 1);
    end
  endtask

  task automatic test_full_board();
    board_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = TW'(4);
    send_move(b);
    wait_done();
    checks++;
    if (done_cyc - accept_cyc + 1 != 20) begin
      errors++;
      $display("FAIL full_latency: got %0d, expected 20", done_cyc - accept_cyc + 1);
    end
  endtask

  task automatic test_win();
    board_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = TW'(8);
    b[1][2] = TW'(2048);
    b[0][3] = '0;
    send_move(b);
    wait_done();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = TW'(16);
    b[3][0] = '0;
    send_move(b);
    wait_done();
    send_new_game();
    checks++;
    if (win !== 1'b0) begin
      errors++;
      $display("FAIL win_clear: got %b, expected 0", win);
    end
  endtask

  task automatic test_random();
    board_t b;
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          b[r][c] = ($urandom_range(0, 2) == 0) ? '0 : TW'(2 << $urandom_range(0, 3));
      send_move(b);
      wait_done();
    end
  endtask

  task automatic test_reset_mid();
    board_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = TW'(32);
    send_move(b);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (spawn_r.size() != 0) begin
      errors++;
      $display("FAIL midrst_prespawn: got %0d spawns, expected 0", spawn_r.size());
    end
    @(negedge clk);
    checks++;
    if (board !== '0) begin errors++; $display("FAIL midrst_board: got %h, expected 0", board); end
    checks++;
    if (move_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b, expected 1", move_ready); end
    checks++;
    if (spawn_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pulses: spawn_valid/done got %b%b, expected 00", spawn_valid, done);
    end
    q.delete();
    spawn_r.delete();
    spawn_c.delete();
    sel_cnt    = 0;
    cur_model  = '0;
    win_model  = 1'b0;
    full_model = 1'b0;
    #1 rst = 1'b0;
  endtask

  task automatic test_busy_ignore();
    board_t b;
    int start;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = TW'(64);
    b[3][3] = '0;
    start = done_cnt;
    send_move(b);
    move_valid = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        moved_board[r][c] = TW'(128);
    repeat (2) @(posedge clk);
    #1 move_valid = 1'b0;
    repeat (60) @(posedge clk);
    checks++;
    if (done_cnt - start != 1) begin
      errors++;
      $display("FAIL busy_done_count: got %0d, expected 1", done_cnt - start);
    end
  endtask

  initial begin
    rst         = 1'b1;
    new_game    = 1'b0;
    move_valid  = 1'b0;
    moved_board = '0;
    test_reset();
    test_new_game();
    test_single_empty();
    test_noop();
    test_full_board();
    test_win();
    test_random();
    test_reset_mid();
    test_busy_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at 2ms, expected completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/board_commit_ctrl.md
Name: board_commit_ctrl

Overview:
- Sequencer for the 2048 board register and its 2-way board mux (select 0 = hold current board, select 1 = load moved board).
- On each move request it captures the moved board from the move logic, detects a no-op move, commits the changed board and spawns a new tile at a pseudo-random empty cell.
- Also runs new-game initialisation and keeps the win and full status flags.

Parameters:
- TILE_W, 12, tile value width.
- WIN_VALUE, 2048, tile value that sets win.
- SPAWN_VALUE, 2, value written into a spawned tile.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- new_game  in  1  pulse; accepted only when move_ready=1.
- move_valid  in  1  pulse; accepted only when move_ready=1 and new_game=0.
- moved_board  in  TILE_W x [3:0][3:0]  candidate board from the move logic; sampled on the accept cycle only.
- move_ready  out  1  high only in IDLE.
- sel  out  1  board mux select; 1 only during the COMMIT cycle.
- board  out  TILE_W x [3:0][3:0]  registered current board.
- spawn_valid  out  1  one-cycle pulse when a tile is written.
- spawn_row, spawn_col  out  2 each  cell written; valid with spawn_valid.
- changed  out  1  valid with done; 1 if the board was altered.
- done  out  1  one-cycle pulse ending every accepted request.
- win  out  1  sticky until rst or new_game.
- full  out  1  registered; 1 iff no zero cell in board, updated on the done cycle.

Behaviour:
- Reset values: board all 0, state IDLE, LFSR=SEED, all outputs 0 except move_ready=1.
- Reset mid-operation aborts immediately; there is no partial commit beyond cycles already clocked.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle, including during reset deassertion.
- Cell index i in 0..15 maps to row=i[3:2], col=i[1:0].
- States and transitions:
  - IDLE: new_game has priority over move_valid.
    - new_game: clear board to 0, clear win, set spawn_cnt=2, go to SEARCH.
    - move_valid: shadow<=moved_board, go to COMPARE.
  - COMPARE: if shadow==board, pulse done with changed=0 and return to IDLE; no spawn, board untouched. Otherwise go to COMMIT.
  - COMMIT: sel=1; board<=shadow; spawn_cnt=1; go to SEARCH.
  - SEARCH: on entry, idx<=LFSR[3:0] and scanned=0. Each cycle test cell idx.
    - Cell is 0: go to SPAWN.
    - Otherwise: idx<=idx+1 mod 16 (wraps 15 to 0), scanned++.
    - scanned reaches 16 with no empty cell: go to FINISH without a spawn.
  - SPAWN: board[idx]<=SPAWN_VALUE; spawn_valid=1 with row/col of idx; spawn_cnt--. If spawn_cnt becomes 0 go to FINISH, else go to SEARCH (fresh LFSR sample).
  - FINISH: done=1; changed=1; full<=(no zero cell in board); win|=(any cell==WIN_VALUE); go to IDLE.
- Latency: accept at cycle N → COMPARE N+1 → COMMIT N+2 (board visible N+3) → SEARCH takes k+1 cycles for k occupied cells skipped → SPAWN → FINISH.
  - Minimum accept-to-done is 6 cycles for a changed move and 2 cycles for a no-op move.
- Handshake: requests that arrive while move_ready=0 are ignored, not queued. moved_board need not stay stable after the accept cycle.
- Arithmetic: compare is full TILE_W equality per cell. The win check is exact equality, not ≥.
- Full board after commit: no spawn, changed=1, full=1.
- After win=1, moves are still accepted; win stays 1.

Test Plan:
- Reset → board all 0, move_ready=1, win=0, full=0, done=0; after rst, new_game → two spawn_valid pulses at distinct cells, board has exactly two cells == 2, done with changed=1.
- Board preloaded via move; move_valid with moved_board == board → done on 2nd cycle after accept, changed=0, sel never 1, no spawn_valid.
- moved_board with 15 nonzero cells and only [2][1]=0 → sel=1 for exactly 1 cycle; spawn at row=2, col=1; board[2][1]=2; full=1 at done.
- moved_board all nonzero (e.g. 4 everywhere) → commit, SEARCH takes 16 cycles, no spawn_valid, done changed=1, full=1.
- moved_board containing one 2048 → win=1 at done and stays 1 through a following move; new_game clears it.
- rst asserted during SEARCH → next cycle board all 0 and move_ready=1, no spawn_valid; move_valid asserted while busy → ignored, exactly one done.
